// File: rtl/fpu_seq_mon_pkg.sv
// Shared types and helpers for the FPU result-sequence monitor.
package fpu_seq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEPTH_DEF = 16;
    localparam int AW        = $clog2(DEPTH_DEF);
    localparam int IW        = AW + 1;

    // Entry counts above the table depth are checked as a full table.
    function automatic int unsigned clamp_n(input int unsigned n, input int unsigned depth);
        return (n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/fpu_seq_mon_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fpu_seq_mon_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int RAM_AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RAM_AW-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fpu_seq_monitor.sv
// FPU result-sequence monitor: checks obs_i against a programmed table in order.
// Optional per-match latency log enabled by defining FPU_SEQ_MON_LATLOG_EN.
module fpu_seq_monitor
    import fpu_seq_mon_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 300000,
    parameter int CNT_W       = 20,
    localparam int TAW        = $clog2(DEPTH),
    localparam int TIW        = TAW + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] obs_i,
    input  logic [TIW-1:0]    n_exp_i,
    input  logic              ld_we_i,
    input  logic [TAW-1:0]    ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [TIW-1:0]    idx_o,
    output logic [DATA_W-1:0] last_o,
    input  logic [TAW-1:0]    lat_raddr_i,
    output logic [CNT_W-1:0]  lat_rdata_o
);

    state_t            r_state, w_state_next;
    logic [TIW-1:0]    r_idx, w_idx_next, r_n, w_n_next, w_idx_inc;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
    logic              r_pass, w_pass_next, r_timeout, w_timeout_next;
    logic [DATA_W-1:0] r_last, w_last_next, w_exp;
    logic              w_tab_we, w_match, w_log_we;

    assign w_tab_we  = ld_we_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_match   = (obs_i == w_exp);
    assign w_idx_inc = r_idx + TIW'(1);
    // Saturates so a long wait in ARM cannot wrap back below the limit.
    assign w_cnt_inc = (r_cnt >= CNT_W'(TIMEOUT_CYC)) ? r_cnt : r_cnt + 1'b1;

    fpu_seq_mon_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_exp_tab (
        .clk     (wb_clk_i),
        .we_i    (w_tab_we),
        .waddr_i (ld_addr_i),
        .wdata_i (ld_data_i),
        .raddr_i (r_idx[TAW-1:0]),
        .rdata_o (w_exp)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_n       <= '0;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_last    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_n       <= w_n_next;
            r_cnt     <= w_cnt_next;
            r_pass    <= w_pass_next;
            r_timeout <= w_timeout_next;
            r_last    <= w_last_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_n_next       = r_n;
        w_cnt_next     = r_cnt;
        w_pass_next    = r_pass;
        w_timeout_next = r_timeout;
        w_last_next    = r_last;
        w_log_we       = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_state_next   = ARM;
                    w_idx_next     = '0;
                    w_n_next       = TIW'(clamp_n(32'(n_exp_i), 32'(DEPTH)));
                    w_cnt_next     = '0;
                    w_pass_next    = 1'b0;
                    w_timeout_next = 1'b0;
                    w_last_next    = '0;
                end
            end
            ARM: begin
                w_cnt_next = w_cnt_inc;
                if (ready_i) begin
                    if (r_n == '0) begin
                        w_state_next = DONE;
                        w_pass_next  = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                // A match in the same cycle as the limit takes priority.
                if (w_match) begin
                    w_log_we   = 1'b1;
                    w_cnt_next = '0;
                    w_idx_next = w_idx_inc;
                    if (w_idx_inc == r_n) begin
                        w_state_next = DONE;
                        w_pass_next  = 1'b1;
                    end
                end else if (r_cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_next   = DONE;
                    w_timeout_next = 1'b1;
                    w_last_next    = obs_i;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy_o    = (r_state == ARM) || (r_state == RUN);
    assign done_o    = (r_state == DONE);
    assign pass_o    = r_pass;
    assign timeout_o = r_timeout;
    assign idx_o     = r_idx;
    assign last_o    = r_last;

`ifdef FPU_SEQ_MON_LATLOG_EN
    // Logged value is cycles elapsed since the previous match (or since arming).
    fpu_seq_mon_ram #(.DATA_W(CNT_W), .DEPTH(DEPTH)) u_lat_log (
        .clk     (wb_clk_i),
        .we_i    (w_log_we),
        .waddr_i (r_idx[TAW-1:0]),
        .wdata_i (w_cnt_inc),
        .raddr_i (lat_raddr_i),
        .rdata_o (lat_rdata_o)
    );
`else
    logic w_unused;
    assign w_unused    = ^{lat_raddr_i, w_log_we};
    assign lat_rdata_o = '0;
`endif

endmodule

// File: tb/tb_fpu_seq_monitor.sv
// Randomized scoreboard bench for fpu_seq_monitor against a per-cycle sequence model.
module tb_fpu_seq_monitor;

    localparam int DW = 32, DEPTH = 16, T = 50, CW = 8, AW = 4, IW = 5;

    logic          clk = 1'b0, rst = 1'b1;
    logic          start_i = 1'b0, ready_i = 1'b0, ld_we_i = 1'b0;
    logic [DW-1:0] obs_i = '0, ld_data_i = '0;
    logic [IW-1:0] n_exp_i = '0;
    logic [AW-1:0] ld_addr_i = '0, lat_raddr_i = '0;
    logic          busy_o, done_o, pass_o, timeout_o;
    logic [IW-1:0] idx_o;
    logic [DW-1:0] last_o;
    logic [CW-1:0] lat_rdata_o;

    fpu_seq_monitor #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .ready_i(ready_i),
        .obs_i(obs_i), .n_exp_i(n_exp_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
        .ld_data_i(ld_data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .timeout_o(timeout_o), .idx_o(idx_o), .last_o(last_o),
        .lat_raddr_i(lat_raddr_i), .lat_rdata_o(lat_rdata_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          pass;
        bit          to;
        int          idx;
        logic [31:0] last;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] tb_exp [DEPTH];
    int          checks = 0, errors = 0, runs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Walks the observed stream one cycle at a time: elapsed cycles since the
    // last match (or since arming) reaching T ends the run with a timeout.
    function automatic void model(input int n_in, input int rdly, input logic [31:0] s[$],
                                  output exp_t e, output int k);
        int n   = (n_in > DEPTH) ? DEPTH : n_in;
        int gap = rdly + 1;
        logic [31:0] v;
        e.pass = 1'b0; e.to = 1'b0; e.idx = 0; e.last = '0; e.cyc = 0; k = 0;
        if (n == 0) begin
            e.pass = 1'b1;
            return;
        end
        for (int j = 0; j < s.size() + T + 8; j++) begin
            v = (j < s.size()) ? s[j] : s[s.size()-1];
            if (v == tb_exp[e.idx]) begin
                e.idx++;
                gap = 0;
                if (e.idx == n) begin
                    e.pass = 1'b1; k = j + 1;
                    return;
                end
            end else begin
                gap++;
                if (gap >= T) begin
                    e.to = 1'b1; e.last = v; k = j + 1;
                    return;
                end
            end
        end
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        ld_we_i = 1'b1; ld_addr_i = AW'(a); ld_data_i = d; tb_exp[a] = d;
        @(posedge clk); #1;
        ld_we_i = 1'b0;
    endtask

    task automatic run_case(input int n, input int rdly, input logic [31:0] s[$],
                            input bit wr0, input logic [31:0] wr0_data);
        exp_t e;
        int   k, c1, w;
        model(n, rdly, s, e, k);
        @(posedge clk); #1;
        start_i = 1'b1; n_exp_i = IW'(n); ready_i = 1'b0;
        if (wr0) begin
            ld_we_i = 1'b1; ld_addr_i = '0; ld_data_i = wr0_data;
        end
        @(posedge clk); #1;
        c1 = cyc;
        start_i = 1'b0; ld_we_i = 1'b0; n_exp_i = IW'($urandom);
        repeat (rdly) begin @(posedge clk); #1; end
        ready_i = 1'b1;
        e.cyc = c1 + rdly + 1 + k;
        q.push_back(e);
        @(posedge clk); #1;
        for (int j = 0; j < k; j++) begin
            obs_i = (j < s.size()) ? s[j] : s[s.size()-1];
            if (j > 0) ready_i = 1'($urandom_range(0, 1));
            start_i = (j == 1);
            @(posedge clk); #1;
        end
        start_i = 1'b0; ready_i = 1'b0;
        w = 0;
        while (q.size() != 0 && w < 5) begin @(posedge clk); #1; w++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_missing actual=0 required=1");
            q.delete();
        end
    endtask

    initial begin
        logic [31:0] s[$];
        logic [31:0] v0, v1, v2, nd;
        int          n, neff, gap;
        bit          w0;

        fork
            begin : monitor
                bit   done_prev = 1'b0;
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (done_o && !done_prev) begin
                        if (q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_done actual=1 required=0");
                        end else begin
                            e = q.pop_front();
                            runs++;
                            $display("run %0d: pass=%0b timeout=%0b idx=%0d last=%08h cyc=%0d",
                                     runs, pass_o, timeout_o, idx_o, last_o, cyc);
                            chk("pass", 64'(pass_o), 64'(e.pass));
                            chk("timeout", 64'(timeout_o), 64'(e.to));
                            chk("idx", 64'(idx_o), 64'(e.idx));
                            chk("last", 64'(last_o), 64'(e.last));
                            chk("done_cycle", 64'(cyc), 64'(e.cyc));
                            chk("busy_at_done", 64'(busy_o), 64'd0);
                        end
                    end
                    done_prev = done_o;
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_pass", 64'(pass_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_idx", 64'(idx_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_lat", 64'(lat_rdata_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) wr(a, $urandom);
        v0 = 32'h4342C190; v1 = 32'hCD883D35; v2 = 32'hC5D1D74D;
        wr(0, v0); wr(1, v1); wr(2, v2);

        // Three results, five cycles apart
        s.delete();
        for (int i = 0; i < 3; i++) begin
            repeat (4) s.push_back(32'h0);
            s.push_back(tb_exp[i]);
        end
        run_case(3, 0, s, 1'b0, '0);
`ifdef FPU_SEQ_MON_LATLOG_EN
        lat_raddr_i = 4'd1; #1;
        chk("lat1", 64'(lat_rdata_o), 64'd5);
        lat_raddr_i = 4'd2; #1;
        chk("lat2", 64'(lat_rdata_o), 64'd5);
`else
        lat_raddr_i = AW'($urandom); #1;
        chk("lat_tied", 64'(lat_rdata_o), 64'd0);
`endif

        // Timeout after one match, bus held at zero
        s.delete(); s.push_back(v0); s.push_back(32'h0);
        run_case(3, 0, s, 1'b0, '0);

        // Timeout while still waiting on entry 0 after a slow ready
        s.delete(); s.push_back(32'h0);
        run_case(2, 3, s, 1'b0, '0);

        // Repeated words, level semantics
        wr(0, 32'h1); wr(1, 32'h1);
        s.delete(); s.push_back(32'h1);
        run_case(2, 0, s, 1'b0, '0);

        // Zero entries, ready after 10 cycles
        s.delete(); s.push_back(32'h0);
        run_case(0, 10, s, 1'b0, '0);

        // Count above DEPTH clamps to a full table
        s.delete();
        for (int i = 0; i < DEPTH; i++) s.push_back(tb_exp[i]);
        run_case(20, 1, s, 1'b0, '0);

        // Reset mid-run at idx 2 with writes attempted during RUN
        wr(0, v0); wr(1, v1); wr(2, v2);
        @(posedge clk); #1;
        start_i = 1'b1; n_exp_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0; ready_i = 1'b1;
        @(posedge clk); #1;
        obs_i = v0;
        @(posedge clk); #1;
        obs_i = v1;
        @(posedge clk); #1;
        obs_i = 32'h0;
        for (int a = 0; a < 3; a++) begin
            ld_we_i = 1'b1; ld_addr_i = AW'(a); ld_data_i = ~tb_exp[a];
            @(posedge clk); #1;
        end
        ld_we_i = 1'b0;
        chk("run_busy", 64'(busy_o), 64'd1);
        chk("run_idx", 64'(idx_o), 64'd2);
        rst = 1'b1; #2;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_idx", 64'(idx_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; ready_i = 1'b0;
        s.delete(); s.push_back(v0); s.push_back(v1); s.push_back(v2);
        run_case(3, 0, s, 1'b0, '0);

        // Randomized runs
        for (int it = 0; it < 14; it++) begin
            repeat (3) wr($urandom_range(0, DEPTH - 1), $urandom);
            w0 = ($urandom_range(0, 3) == 0);
            nd = $urandom;
            if (w0) tb_exp[0] = nd;
            n    = $urandom_range(1, 20);
            neff = (n > DEPTH) ? DEPTH : n;
            s.delete();
            for (int i = 0; i < neff; i++) begin
                gap = $urandom_range(0, 4);
                if ((it % 5) == 4 && i == neff / 2) gap = T + 5;
                repeat (gap) s.push_back($urandom);
                s.push_back(tb_exp[i]);
            end
            run_case(n, $urandom_range(0, 3), s, w0, nd);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
